// File: rtl/memory_arbiter_if.sv
// Bus bundle between instruction/data requesters, the arbiter and a single-port RAM.
// The slave modport is the arbiter's view; master is the requester/RAM-model view.
interface memory_arbiter_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        ihit;
  logic        dhit;
  logic [31:0] iload;
  logic [31:0] dload;
  logic        memerr;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output ihit, dhit, iload, dload, memerr, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  ihit, dhit, iload, dload, memerr, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/memory_arbiter.sv
// Arbitrates instruction and data requests onto one RAM port, data first.
// Each access ends on ACCESS, ERROR or a wait timeout, then pulses one hit in RESP.
module memory_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  memory_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, IACC, DACC, RESP} state_t;

  localparam logic [1:0] RamAccess   = 2'd2;
  localparam logic [1:0] RamError    = 2'd3;
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_addr;
  logic [31:0] r_store;
  logic [31:0] r_iload;
  logic [31:0] r_dload;
  logic        r_write;
  logic        r_isData;
  logic        r_err;
  logic [7:0]  r_cnt;

  logic w_dataReq;
  logic w_inAcc;
  logic w_access;
  logic w_error;
  logic w_timeout;

  assign w_dataReq = bus.dREN | bus.dWEN;
  assign w_inAcc   = (r_state == IACC) || (r_state == DACC);
  assign w_access  = bus.ramstate == RamAccess;
  assign w_error   = bus.ramstate == RamError;
  assign w_timeout = r_cnt == TimeoutLast;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_dataReq)     w_next = DACC;
        else if (bus.iREN) w_next = IACC;
      end
      IACC, DACC: begin
        if (w_access || w_error || w_timeout) w_next = RESP;
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Request fields are frozen on leaving IDLE so requester changes cannot disturb the access.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_addr   <= '0;
      r_store  <= '0;
      r_write  <= 1'b0;
      r_isData <= 1'b0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
      r_iload  <= '0;
      r_dload  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_next != IDLE) begin
            r_addr   <= w_dataReq ? bus.daddr : bus.iaddr;
            r_store  <= bus.dstore;
            r_write  <= w_dataReq & bus.dWEN;
            r_isData <= w_dataReq;
            r_err    <= 1'b0;
            r_cnt    <= '0;
          end
        end
        IACC, DACC: begin
          if (w_access) begin
            if (!r_write) begin
              if (r_isData) r_dload <= bus.ramload;
              else          r_iload <= bus.ramload;
            end
          end else if (w_error || w_timeout) begin
            r_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ramREN   = (r_state == IACC) || ((r_state == DACC) && !r_write);
  assign bus.ramWEN   = (r_state == DACC) && r_write;
  assign bus.ramaddr  = w_inAcc ? r_addr : 32'd0;
  assign bus.ramstore = w_inAcc ? r_store : 32'd0;
  assign bus.ihit     = (r_state == RESP) && !r_isData;
  assign bus.dhit     = (r_state == RESP) && r_isData;
  assign bus.memerr   = (r_state == RESP) && r_err;
  assign bus.iload    = r_iload;
  assign bus.dload    = r_dload;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed-vector bench for memory_arbiter: each row is checked at a falling edge, then its inputs are applied.
// Expected outputs in a row describe the cycle produced by the previous rows' inputs.
module tb_memory_arbiter;

  localparam logic [1:0] FREE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] ACC  = 2'd2;
  localparam logic [1:0] ERR  = 2'd3;
  localparam logic [31:0] IL1 = 32'h3C010001;
  localparam logic [31:0] IL2 = 32'h22222222;
  localparam logic [31:0] DL1 = 32'hCAFEF00D;

  typedef struct {
    logic        iren, dren, dwen;
    logic [31:0] ia, da, ds, rl;
    logic [1:0]  rs;
    logic        rren, rwen;
    logic [31:0] raddr, rstore;
    logic        ihit, dhit, merr;
    logic [31:0] iload, dload;
  } vec_t;

  logic CLK;
  logic nRST;
  int   total = 0;
  int   bad = 0;
  vec_t vecs[$];

  memory_arbiter_if bus();

  memory_arbiter #(.TIMEOUT(4)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.iREN     = v.iren;
    bus.dREN     = v.dren;
    bus.dWEN     = v.dwen;
    bus.iaddr    = v.ia;
    bus.daddr    = v.da;
    bus.dstore   = v.ds;
    bus.ramload  = v.rl;
    bus.ramstate = v.rs;
  endtask

  task automatic addVec(input logic iren, dren, dwen, input logic [31:0] ia, da, ds, rl,
                        input logic [1:0] rs, input logic rren, rwen,
                        input logic [31:0] raddr, rstore, input logic ihit, dhit, merr,
                        input logic [31:0] il, dl);
    vec_t v;
    v.iren = iren; v.dren = dren; v.dwen = dwen;
    v.ia = ia; v.da = da; v.ds = ds; v.rl = rl; v.rs = rs;
    v.rren = rren; v.rwen = rwen; v.raddr = raddr; v.rstore = rstore;
    v.ihit = ihit; v.dhit = dhit; v.merr = merr; v.iload = il; v.dload = dl;
    vecs.push_back(v);
  endtask

  task automatic checkRow(input string pfx, input vec_t v);
    checkOutput({pfx, " ramREN"},   32'(bus.ramREN),  32'(v.rren));
    checkOutput({pfx, " ramWEN"},   32'(bus.ramWEN),  32'(v.rwen));
    checkOutput({pfx, " ramaddr"},  bus.ramaddr,      v.raddr);
    checkOutput({pfx, " ramstore"}, bus.ramstore,     v.rstore);
    checkOutput({pfx, " ihit"},     32'(bus.ihit),    32'(v.ihit));
    checkOutput({pfx, " dhit"},     32'(bus.dhit),    32'(v.dhit));
    checkOutput({pfx, " memerr"},   32'(bus.memerr),  32'(v.merr));
    checkOutput({pfx, " iload"},    bus.iload,        v.iload);
    checkOutput({pfx, " dload"},    bus.dload,        v.dload);
  endtask

  initial begin
    vec_t idleVec;
    // Instruction read: two BUSY cycles then ACCESS
    addVec(1,0,0,'h40,0,0,0,BUSY,              0,0,0,0,0,0,0,0,0);
    addVec(1,0,0,'h40,0,0,0,BUSY,              1,0,'h40,0,0,0,0,0,0);
    addVec(1,0,0,'h40,0,0,0,BUSY,              1,0,'h40,0,0,0,0,0,0);
    addVec(1,0,0,'h40,0,0,IL1,ACC,             1,0,'h40,0,0,0,0,0,0);
    addVec(0,0,0,0,0,0,0,FREE,                 0,0,0,0,1,0,0,IL1,0);
    // Simultaneous instruction and data write: data goes first
    addVec(1,0,1,'h44,'h80,'hDEADBEEF,'h11111111,ACC, 0,0,0,0,0,0,0,IL1,0);
    addVec(1,0,1,'h44,'h80,'hDEADBEEF,'h11111111,ACC, 0,1,'h80,'hDEADBEEF,0,0,0,IL1,0);
    addVec(1,0,0,'h44,0,0,IL2,ACC,             0,0,0,0,0,1,0,IL1,0);
    addVec(1,0,0,'h44,0,0,IL2,ACC,             0,0,0,0,0,0,0,IL1,0);
    addVec(1,0,0,'h44,0,0,IL2,ACC,             1,0,'h44,0,0,0,0,IL1,0);
    // Data read with immediate ACCESS
    addVec(0,1,0,0,'h200,0,DL1,ACC,            0,0,0,0,1,0,0,IL2,0);
    addVec(0,1,0,0,'h200,0,DL1,ACC,            0,0,0,0,0,0,0,IL2,0);
    addVec(0,1,0,0,'h200,0,DL1,ACC,            1,0,'h200,0,0,0,0,IL2,0);
    addVec(0,0,0,0,0,0,0,FREE,                 0,0,0,0,0,1,0,IL2,DL1);
    // Timeout with TIMEOUT=4: four strobe cycles then an erroring hit
    addVec(0,1,0,0,'h300,0,'hBAD0BAD0,BUSY,    0,0,0,0,0,0,0,IL2,DL1);
    for (int i = 0; i < 4; i++)
      addVec(0,1,0,0,'h300,0,'hBAD0BAD0,BUSY,  1,0,'h300,0,0,0,0,IL2,DL1);
    addVec(0,0,0,0,0,0,0,FREE,                 0,0,0,0,0,1,1,IL2,DL1);
    // ERROR on the second access cycle
    addVec(0,1,0,0,'h400,0,'h55555555,BUSY,    0,0,0,0,0,0,0,IL2,DL1);
    addVec(0,1,0,0,'h400,0,'h55555555,BUSY,    1,0,'h400,0,0,0,0,IL2,DL1);
    addVec(0,1,0,0,'h400,0,'h55555555,ERR,     1,0,'h400,0,0,0,0,IL2,DL1);
    addVec(0,0,0,0,0,0,0,FREE,                 0,0,0,0,0,1,1,IL2,DL1);
    // dREN and dWEN together: a write
    addVec(0,1,1,0,'h500,'h12345678,0,ACC,     0,0,0,0,0,0,0,IL2,DL1);
    addVec(0,1,1,0,'h500,'h12345678,0,ACC,     0,1,'h500,'h12345678,0,0,0,IL2,DL1);
    addVec(0,0,0,0,0,0,0,FREE,                 0,0,0,0,0,1,0,IL2,DL1);
    // Write held in BUSY, interrupted by reset below
    addVec(0,0,1,0,'h600,'hA5A5A5A5,0,BUSY,    0,0,0,0,0,0,0,IL2,DL1);
    addVec(0,0,1,0,'h600,'hA5A5A5A5,0,BUSY,    0,1,'h600,'hA5A5A5A5,0,0,0,IL2,DL1);

    idleVec = vecs[4];
    idleVec.rl = 32'h77777777;

    nRST = 1'b0;
    applyStimulus(idleVec);
    #3;
    checkRow("reset", vecs[0]);
    @(posedge CLK);
    #2 nRST = 1'b1;

    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge CLK);
      checkRow($sformatf("row%0d", k), vecs[k]);
      applyStimulus(vecs[k]);
    end

    #2 nRST = 1'b0;
    #1;
    checkOutput("rstmid ramWEN",   32'(bus.ramWEN), 32'd0);
    checkOutput("rstmid ramaddr",  bus.ramaddr,     32'd0);
    checkOutput("rstmid ramstore", bus.ramstore,    32'd0);
    checkOutput("rstmid dhit",     32'(bus.dhit),   32'd0);
    checkOutput("rstmid iload",    bus.iload,       32'd0);
    checkOutput("rstmid dload",    bus.dload,       32'd0);
    applyStimulus(idleVec);
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    checkOutput("post ramWEN", 32'(bus.ramWEN), 32'd0);
    checkOutput("post dhit",   32'(bus.dhit),   32'd0);
    idleVec.iren = 1'b1;
    idleVec.ia   = 32'h700;
    idleVec.rs   = ACC;
    applyStimulus(idleVec);
    @(negedge CLK);
    checkOutput("post ramREN",  32'(bus.ramREN), 32'd1);
    checkOutput("post ramaddr", bus.ramaddr,     32'h700);
    idleVec.iren = 1'b0;
    applyStimulus(idleVec);
    @(negedge CLK);
    checkOutput("post ihit",  32'(bus.ihit), 32'd1);
    checkOutput("post iload", bus.iload,     32'h77777777);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
